audio_mix_stream: RTL

Parametrised N-channel stereo mixer with an output sample FIFO. It sits between the project's sound sources and the codec controller's write port. It collects one sample from every routed source channel, then sums, attenuates and saturates them into left and right mixes. Frames are buffered and drained to the codec using its `audio_out_allowed` / `write_audio_out` handshake, and underruns are flagged.

---
 rtl/audio_pkg.sv | 52 +++++
 rtl/audio_sample_fifo.sv | 80 ++++++++
 rtl/audio_mix_stream.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audio_pkg
//  Description : Shared definitions for the stereo mixer slice.
//                - Mixer FSM state encoding (IDLE / ACC / PUSH)
//                - Route bit positions inside a channel's 2-bit route field
//                - Saturation helper that classifies a wide signed value
//                  against the signed range of a narrower width
//  Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_PUSH = 2'd2
   } mix_state_t;

   // Bit positions inside each channel's 2-bit route field.
   localparam int ROUTE_L = 0;
   localparam int ROUTE_R = 1;

   // Width of the value handed to sat_clip; callers sign-extend into it.
   localparam int SAT_IN_W = 64;

   typedef enum logic [1:0] {
      CLIP_NONE = 2'd0,
      CLIP_POS  = 2'd1,
      CLIP_NEG  = 2'd2
   } clip_t;

   // Reports whether a signed value fits in a signed field of the given
   // width, or which rail it must be clamped to.  The caller substitutes the
   // rail value, which keeps this helper independent of the sample width.
   function automatic clip_t sat_clip(input logic signed [SAT_IN_W-1:0] value,
                                      input int                         width);
      logic signed [SAT_IN_W-1:0] v_one;
      logic signed [SAT_IN_W-1:0] v_max;
      logic signed [SAT_IN_W-1:0] v_min;
      v_one = SAT_IN_W'(1);
      v_max = (v_one <<< (width - 1)) - v_one;
      v_min = -(v_one <<< (width - 1));
      if (value > v_max) begin
         return CLIP_POS;
      end else if (value < v_min) begin
         return CLIP_NEG;
      end
      return CLIP_NONE;
   endfunction

endpackage : audio_pkg
`default_nettype wire

// File: rtl/audio_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : audio_sample_fifo
//  Description : Register-based first-word-fall-through FIFO holding mixed
//                stereo frames.  The head entry is always presented on
//                o_head; a pop simply advances the read pointer.
//  Ports       : clk, rst        clock and synchronous active-high reset
//                i_push, i_push_data   write a frame (ignored when full
//                                      unless a pop happens the same cycle)
//                i_pop           discard the head (ignored when empty)
//                o_head          frame at the head (stale when empty)
//                o_level         number of frames held, 0..DEPTH
//                o_empty, o_full occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_sample_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_lvl_w = c_ptr_w + 1;

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_lvl_w-1:0] r_level;

   logic w_do_push;
   logic w_do_pop;

   assign o_empty   = (r_level == '0);
   assign o_full    = (r_level == c_lvl_w'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   assign o_head  = r_mem[r_rd_ptr];
   assign o_level = r_level;

   // Storage needs no reset: nothing reads an entry before it is written,
   // and the empty flag masks the head at the top level.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + c_lvl_w'(1);
            2'b01:   r_level <= r_level - c_lvl_w'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule : audio_sample_fifo
`default_nettype wire

// File: rtl/audio_mix_stream.sv
`default_nettype none
// ============================================================================
//  Module      : audio_mix_stream
//  Description : N-channel stereo mixer feeding the codec write port.
//                Collects one sample from every routed channel (one channel
//                per cycle), sums into wide left/right accumulators, applies
//                an arithmetic right shift, saturates to SAMPLE_W and queues
//                the frame in an output FIFO drained by the codec handshake.
//  Ports       : CLOCK_50, reset        clock, synchronous active-high reset
//                ch_sample / ch_valid / ch_ready   per-channel source stream
//                ch_route               2 bits per channel {R, L}; 00 = muted
//                gain_shift             right shift applied to both mixes
//                audio_out_allowed / write_audio_out   codec handshake
//                left/right_channel_audio_out   frame at FIFO head (0 if empty)
//                fifo_level             frames buffered
//                underrun               sticky: codec asked while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_mix_stream
   import audio_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int SAMPLE_W   = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                           CLOCK_50,
   input  logic                           reset,
   input  logic [NUM_CH*SAMPLE_W-1:0]     ch_sample,
   input  logic [NUM_CH-1:0]              ch_valid,
   output logic [NUM_CH-1:0]              ch_ready,
   input  logic [NUM_CH*2-1:0]            ch_route,
   input  logic [3:0]                     gain_shift,
   input  logic                           audio_out_allowed,
   output logic                           write_audio_out,
   output logic [SAMPLE_W-1:0]            left_channel_audio_out,
   output logic [SAMPLE_W-1:0]            right_channel_audio_out,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           underrun
);

   // The accumulator is one sign bit plus log2(NUM_CH) growth bits wider
   // than a sample, so summing every channel can never wrap.  It must stay
   // narrower than SAT_IN_W for the saturation helper.
   localparam int c_acc_w  = SAMPLE_W + $clog2(NUM_CH) + 1;
   localparam int c_idx_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int c_lvl_w  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(NUM_CH - 1);
   localparam logic [SAMPLE_W-1:0] c_sat_max  = {1'b0, {(SAMPLE_W-1){1'b1}}};
   localparam logic [SAMPLE_W-1:0] c_sat_min  = {1'b1, {(SAMPLE_W-1){1'b0}}};

   mix_state_t                 r_state;
   mix_state_t                 w_next_state;
   logic [c_idx_w-1:0]         r_idx;
   logic signed [c_acc_w-1:0]  r_acc_l;
   logic signed [c_acc_w-1:0]  r_acc_r;
   logic [NUM_CH*2-1:0]        r_route;
   logic [3:0]                 r_shift;
   logic                       r_primed;
   logic                       r_underrun;

   logic [NUM_CH-1:0]          w_live_routed;
   logic [NUM_CH-1:0]          w_latched_routed;
   logic                       w_sources_ready;
   logic [SAMPLE_W-1:0]        w_sample;
   logic [1:0]                 w_cur_route;
   logic signed [c_acc_w-1:0]  w_sample_ext;
   logic signed [c_acc_w-1:0]  w_shift_l;
   logic signed [c_acc_w-1:0]  w_shift_r;
   logic signed [SAT_IN_W-1:0] w_wide_l;
   logic signed [SAT_IN_W-1:0] w_wide_r;
   logic [SAMPLE_W-1:0]        w_mix_l;
   logic [SAMPLE_W-1:0]        w_mix_r;
   logic                       w_push;
   logic [2*SAMPLE_W-1:0]      w_fifo_head;
   logic [c_lvl_w-1:0]         w_fifo_level;
   logic                       w_fifo_empty;
   logic                       w_fifo_full;

   // ---------------------------------------------------------------------
   // Route decode: a channel takes part in a frame when either bit is set.
   // ---------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_route
      assign w_live_routed[gi]    = |ch_route[2*gi +: 2];
      assign w_latched_routed[gi] = |r_route[2*gi +: 2];
   end

   // Muted channels are never waited on; with every channel muted this
   // reduces to "FIFO not full" and silence frames keep the codec fed.
   assign w_sources_ready = &(ch_valid | ~w_live_routed);

   // Select the channel being visited in ACC.
   always_comb begin
      w_sample    = '0;
      w_cur_route = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_idx == c_idx_w'(i)) begin
            w_sample    = ch_sample[i*SAMPLE_W +: SAMPLE_W];
            w_cur_route = r_route[2*i +: 2];
         end
      end
   end

   assign w_sample_ext = {{(c_acc_w-SAMPLE_W){w_sample[SAMPLE_W-1]}}, w_sample};

   // ---------------------------------------------------------------------
   // Mixer FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      ch_ready     = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_sources_ready && !w_fifo_full) begin
               w_next_state = ST_ACC;
            end
         end
         ST_ACC: begin
            if (r_idx == c_last_idx) begin
               w_next_state = ST_PUSH;
            end
         end
         ST_PUSH: begin
            w_push       = 1'b1;
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase

      // Muted channels are held ready so their sources never stall.  While
      // a frame is in flight the latched routing decides who is muted, so a
      // mid-frame route change cannot release a channel still owed a pulse.
      if (!reset) begin
         if (r_state == ST_IDLE) begin
            ch_ready = ~w_live_routed;
         end else begin
            ch_ready = ~w_latched_routed;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if ((r_state == ST_ACC) && (r_idx == c_idx_w'(i)) && w_latched_routed[i]) begin
               ch_ready[i] = 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Accumulation datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_idx   <= '0;
         r_acc_l <= '0;
         r_acc_r <= '0;
         r_route <= '0;
         r_shift <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_next_state == ST_ACC) begin
                  r_route <= ch_route;
                  r_shift <= gain_shift;
                  r_acc_l <= '0;
                  r_acc_r <= '0;
                  r_idx   <= '0;
               end
            end
            ST_ACC: begin
               if (w_cur_route[ROUTE_L]) begin
                  r_acc_l <= r_acc_l + w_sample_ext;
               end
               if (w_cur_route[ROUTE_R]) begin
                  r_acc_r <= r_acc_r + w_sample_ext;
               end
               r_idx <= r_idx + c_idx_w'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Attenuate and saturate (consumed only in PUSH)
   // ---------------------------------------------------------------------
   assign w_shift_l = r_acc_l >>> r_shift;
   assign w_shift_r = r_acc_r >>> r_shift;
   assign w_wide_l  = {{(SAT_IN_W-c_acc_w){w_shift_l[c_acc_w-1]}}, w_shift_l};
   assign w_wide_r  = {{(SAT_IN_W-c_acc_w){w_shift_r[c_acc_w-1]}}, w_shift_r};

   always_comb begin
      w_mix_l = w_shift_l[SAMPLE_W-1:0];
      unique case (sat_clip(w_wide_l, SAMPLE_W))
         CLIP_POS: w_mix_l = c_sat_max;
         CLIP_NEG: w_mix_l = c_sat_min;
         default:  w_mix_l = w_shift_l[SAMPLE_W-1:0];
      endcase
   end

   always_comb begin
      w_mix_r = w_shift_r[SAMPLE_W-1:0];
      unique case (sat_clip(w_wide_r, SAMPLE_W))
         CLIP_POS: w_mix_r = c_sat_max;
         CLIP_NEG: w_mix_r = c_sat_min;
         default:  w_mix_r = w_shift_r[SAMPLE_W-1:0];
      endcase
   end

   // ---------------------------------------------------------------------
   // Output frame FIFO and codec drain
   // ---------------------------------------------------------------------
   audio_sample_fifo #(
      .WIDTH (2*SAMPLE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (CLOCK_50),
      .rst         (reset),
      .i_push      (w_push),
      .i_push_data ({w_mix_l, w_mix_r}),
      .i_pop       (write_audio_out),
      .o_head      (w_fifo_head),
      .o_level     (w_fifo_level),
      .o_empty     (w_fifo_empty),
      .o_full      (w_fifo_full)
   );

   // Zero-cycle response to the codec from registered FIFO state.
   assign write_audio_out         = audio_out_allowed & ~w_fifo_empty;
   assign left_channel_audio_out  = w_fifo_empty ? '0 : w_fifo_head[2*SAMPLE_W-1:SAMPLE_W];
   assign right_channel_audio_out = w_fifo_empty ? '0 : w_fifo_head[SAMPLE_W-1:0];
   assign fifo_level              = w_fifo_level;

   // Underrun is only meaningful once the stream has started, hence the
   // primed bit set by the first push.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_primed   <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         if (w_push) begin
            r_primed <= 1'b1;
         end
         if (r_primed && audio_out_allowed && w_fifo_empty) begin
            r_underrun <= 1'b1;
         end
      end
   end

   assign underrun = r_underrun;

endmodule : audio_mix_stream
`default_nettype wire
